// File: rtl/t_accum.sv
// Cosine-weighted cumulative spectrum sums T0/T1/T2 over one frame of bins,
// emitting running totals at each segment boundary for the formant phi stage.
module t_accum #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COS_WIDTH  = 16,
  parameter int unsigned I          = 160,
  parameter int unsigned FORMANTS   = 5,
  parameter int unsigned NU_VALUES  = 3
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic                                      frame_start,
  input  logic [FORMANTS-1:0][$clog2(I)-1:0]        boundaries,
  input  logic [DATA_WIDTH-1:0]                     bin_data,
  input  logic                                      bin_valid,
  output logic [NU_VALUES-1:0][BIT_WIDTH-1:0]       T_vals,
  output logic                                      t_start,
  output logic                                      t_valid,
  output logic                                      busy
);

  localparam int unsigned KW  = $clog2(I);
  localparam int unsigned KCW = $clog2(I + 1);
  localparam int unsigned FW  = $clog2(FORMANTS + 1);
  localparam int unsigned RW  = $clog2(2 * I);
  localparam int unsigned PW  = DATA_WIDTH + COS_WIDTH;
  localparam int unsigned SW  = (((PW + 1) > BIT_WIDTH) ? (PW + 1) : BIT_WIDTH) + 1;

  localparam logic signed [COS_WIDTH-1:0] C_ONE  = COS_WIDTH'(1 << (COS_WIDTH - 2));
  localparam logic signed [SW-1:0]        SAT_HI = SW'({(BIT_WIDTH-1){1'b1}});
  localparam logic signed [SW-1:0]        SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH} state_e;

  // Rounded Q1.14 cosine over a half turn plus the next half turn.
  function automatic logic signed [COS_WIDTH-1:0] cos_word(input int unsigned j);
    real v;
    v = (2.0 ** (COS_WIDTH - 2)) * $cos(3.141592653589793 * real'(j) / real'(I));
    if (v >= 0.0) return COS_WIDTH'($rtoi(v + 0.5));
    else          return COS_WIDTH'(-$rtoi(0.5 - v));
  endfunction

  logic signed [COS_WIDTH-1:0] cos_rom [2*I];
  for (genvar j = 0; j < 2 * I; j++) begin : g_rom
    assign cos_rom[j] = cos_word(j);
  end

  state_e                           state_q, state_d;
  logic [KCW-1:0]                   k_q, k_d;
  logic [FW-1:0]                    f_q, f_d;
  logic [FORMANTS-1:0][KW-1:0]      bnd_q, bnd_d;
  logic                             v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [DATA_WIDTH-1:0]            p0_q, p0_d, p1_q, p1_d;
  logic [KW-1:0]                    k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
  logic signed [COS_WIDTH-1:0]      c1_q, c1_d, c2_q, c2_d;
  logic signed [BIT_WIDTH-1:0]      acc_q [NU_VALUES];
  logic signed [BIT_WIDTH-1:0]      acc_d [NU_VALUES];
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] tvals_q, tvals_d;
  logic                             t_start_q, t_start_d, t_valid_q, t_valid_d, busy_q, busy_d;

  logic signed [COS_WIDTH-1:0]      coef_c [NU_VALUES];
  logic signed [PW:0]               prod_c [NU_VALUES];
  logic signed [SW-1:0]             sum_c  [NU_VALUES];
  logic                             emit_c;

  // T0 lives at the top index so T_vals reads {T0,T1,T2}.
  always_comb begin
    coef_c[NU_VALUES-1] = C_ONE;
    coef_c[1]           = c1_q;
    coef_c[0]           = c2_q;
    for (int i = 0; i < NU_VALUES; i++) begin
      prod_c[i] = (PW+1)'($signed({1'b0, p1_q})) * (PW+1)'(coef_c[i]);
      sum_c[i]  = SW'(acc_q[i]) + SW'(prod_c[i]);
    end
  end

  assign emit_c = v2_q && (f_q < FW'(FORMANTS)) && (k2_q >= bnd_q[f_q]);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    f_d       = f_q;
    bnd_d     = bnd_q;
    v0_d      = 1'b0;
    p0_d      = p0_q;
    k0_d      = k0_q;
    v1_d      = v0_q;
    p1_d      = p0_q;
    k1_d      = k0_q;
    // k < I, so 2k already lies inside the 2I-word table.
    c1_d      = cos_rom[RW'(k0_q)];
    c2_d      = cos_rom[RW'({k0_q, 1'b0})];
    v2_d      = v1_q;
    k2_d      = k1_q;
    acc_d     = acc_q;
    tvals_d   = tvals_q;
    t_start_d = 1'b0;
    t_valid_d = 1'b0;
    busy_d    = busy_q;

    if (v1_q) begin
      for (int i = 0; i < NU_VALUES; i++) begin
        if (sum_c[i] > SAT_HI)      acc_d[i] = BIT_WIDTH'(SAT_HI);
        else if (sum_c[i] < SAT_LO) acc_d[i] = BIT_WIDTH'(SAT_LO);
        else                        acc_d[i] = BIT_WIDTH'(sum_c[i]);
      end
    end

    unique case (state_q)
      S_IDLE: ;
      S_ACCUM: begin
        if (bin_valid && (k_q < KCW'(I))) begin
          v0_d = 1'b1;
          p0_d = bin_data;
          k0_d = KW'(k_q);
          k_d  = k_q + KCW'(1);
        end
        if (emit_c) begin
          for (int i = 0; i < NU_VALUES; i++) tvals_d[i] = acc_q[i];
          t_valid_d = 1'b1;
          f_d       = f_q + FW'(1);
          if (f_q == FW'(FORMANTS - 1)) busy_d = 1'b0;
        end
        if (v2_q && (k2_q == KW'(I - 1)))
          state_d = (f_d < FW'(FORMANTS)) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        for (int i = 0; i < NU_VALUES; i++) tvals_d[i] = acc_q[i];
        t_valid_d = 1'b1;
        f_d       = f_q + FW'(1);
        if (f_q == FW'(FORMANTS - 1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Restart wins over everything, including a bin offered this cycle.
    if (frame_start) begin
      state_d   = S_ACCUM;
      bnd_d     = boundaries;
      k_d       = '0;
      f_d       = '0;
      v0_d      = 1'b0;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
      for (int i = 0; i < NU_VALUES; i++) acc_d[i] = '0;
      t_start_d = 1'b1;
      t_valid_d = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      f_q       <= '0;
      bnd_q     <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      p0_q      <= '0;
      p1_q      <= '0;
      k0_q      <= '0;
      k1_q      <= '0;
      k2_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      for (int i = 0; i < NU_VALUES; i++) acc_q[i] <= '0;
      tvals_q   <= '0;
      t_start_q <= 1'b0;
      t_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      f_q       <= f_d;
      bnd_q     <= bnd_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      k0_q      <= k0_d;
      k1_q      <= k1_d;
      k2_q      <= k2_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      for (int i = 0; i < NU_VALUES; i++) acc_q[i] <= acc_d[i];
      tvals_q   <= tvals_d;
      t_start_q <= t_start_d;
      t_valid_q <= t_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign T_vals  = tvals_q;
  assign t_start = t_start_q;
  assign t_valid = t_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_t_accum.sv
// Scoreboard bench for t_accum: directed frames push expected totals,
// a negedge monitor pops and compares on every t_valid.
module tb_t_accum;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 frame_start;
  logic [4:0][7:0]      boundaries;
  logic [15:0]          bin_data;
  logic                 bin_valid;
  logic [2:0][31:0]     T_vals;
  logic                 t_start, t_valid, busy;

  t_accum dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .boundaries  (boundaries),
    .bin_data    (bin_data),
    .bin_valid   (bin_valid),
    .T_vals      (T_vals),
    .t_start     (t_start),
    .t_valid     (t_valid),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit chk12;
    bit last;
    int t0;
    int t1;
    int t2;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    n_tst  = 0;
  int    n_fs   = 0;
  string tag    = "reset";

  localparam int ONE = 16384;

  task automatic check(input string nm, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d want %0d", tag, nm, got, want);
    end
  endtask

  task automatic push(input int t0, input bit chk12, input int t1, input int t2, input bit last);
    exp_t e;
    e.t0 = t0; e.chk12 = chk12; e.t1 = t1; e.t2 = t2; e.last = last;
    sb.push_back(e);
  endtask

  function automatic logic [4:0][7:0] mk(input int a0, input int a1, input int a2,
                                         input int a3, input int a4);
    logic [4:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3); r[4] = 8'(a4);
    return r;
  endfunction

  function automatic logic [15:0] p_of(input int mode, input int k);
    case (mode)
      1:       return 16'd1;
      2:       return (k == 40) ? 16'd1000 : 16'd0;
      3:       return 16'hFFFF;
      default: return 16'd2;
    endcase
  endfunction

  // Monitor: pop one expectation per t_valid and compare totals and busy.
  always @(negedge clk_in) begin
    if (rst_in && t_start) n_tst++;
    if (rst_in && t_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_t_valid_T0", $signed(T_vals[2]), -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("T0", $signed(T_vals[2]), e.t0);
        if (e.chk12) begin
          check("T1", $signed(T_vals[1]), e.t1);
          check("T2", $signed(T_vals[0]), e.t2);
        end
        check("busy_at_emit", busy, e.last ? 0 : 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_frame(input logic [4:0][7:0] b, input bit with_bin, input logic [15:0] d);
    frame_start = 1'b1;
    boundaries  = b;
    bin_valid   = with_bin;
    bin_data    = d;
    n_fs++;
    tick();
    frame_start = 1'b0;
    bin_valid   = 1'b0;
    check("t_start_pulse", t_start, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int mode, input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 11 == 5) begin
        bin_valid = 1'b0;
        tick();
      end
      bin_valid = 1'b1;
      bin_data  = p_of(mode, k);
      tick();
    end
    bin_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (busy && c < 400) begin
      @(negedge clk_in);
      c++;
    end
    check("busy_drops", busy, 0);
    repeat (4) @(negedge clk_in);
    check("scoreboard_drained", sb.size(), 0);
    #1;
  endtask

  task automatic push_ramp(input int scale, input int t1_final);
    push(32 * scale * ONE, 1'b0, 0, 0, 1'b0);
    push(64 * scale * ONE, 1'b0, 0, 0, 1'b0);
    push(96 * scale * ONE, 1'b0, 0, 0, 1'b0);
    push(128 * scale * ONE, 1'b0, 0, 0, 1'b0);
    push(160 * scale * ONE, 1'b1, t1_final, 0, 1'b1);
  endtask

  logic [4:0][7:0] b_std, b_late;

  initial begin
    b_std       = mk(31, 63, 95, 127, 159);
    b_late      = mk(100, 110, 120, 130, 159);
    rst_in      = 1'b0;
    frame_start = 1'b0;
    boundaries  = '0;
    bin_data    = '0;
    bin_valid   = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    tick();
    check("rst_T0", $signed(T_vals[2]), 0);
    check("rst_flags", {t_start, t_valid, busy}, 0);

    tag = "ones";
    push_ramp(1, ONE);
    start_frame(b_std, 1'b0, '0);
    feed(1, 160);
    wait_done();

    tag = "spike40";
    push(0, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) push(16384000, 1'b1, 11585000, 0, i == 3);
    start_frame(b_std, 1'b0, '0);
    feed(2, 160);
    wait_done();

    tag = "saturate";
    push(1073725440, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) push(2147483647, 1'b0, 0, 0, i == 3);
    start_frame(mk(0, 31, 63, 127, 159), 1'b0, '0);
    feed(3, 160);
    wait_done();

    tag = "nonmono";
    push(32 * ONE, 1'b0, 0, 0, 1'b0);
    push(33 * ONE, 1'b0, 0, 0, 1'b0);
    push(34 * ONE, 1'b0, 0, 0, 1'b0);
    push(128 * ONE, 1'b0, 0, 0, 1'b0);
    push(160 * ONE, 1'b1, ONE, 0, 1'b1);
    start_frame(mk(31, 31, 10, 127, 159), 1'b0, '0);
    feed(1, 160);
    wait_done();

    tag = "abort";
    start_frame(b_late, 1'b0, '0);
    feed(1, 50);
    push_ramp(2, 2 * ONE);
    start_frame(b_std, 1'b1, 16'd1000);
    feed(4, 160);
    wait_done();

    tag = "midreset";
    start_frame(b_late, 1'b0, '0);
    feed(1, 70);
    rst_in = 1'b0;
    #1;
    check("async_rst_T0", $signed(T_vals[2]), 0);
    check("async_rst_T1", $signed(T_vals[1]), 0);
    check("async_rst_flags", {t_start, t_valid, busy}, 0);
    tick();
    rst_in = 1'b1;
    feed(1, 20);
    repeat (6) tick();
    check("idle_after_rst_busy", busy, 0);
    push_ramp(1, ONE);
    start_frame(b_std, 1'b0, '0);
    feed(1, 160);
    wait_done();

    tag = "final";
    check("t_start_count", n_tst, n_fs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
